// File: rtl/output_flow_control.sv
// Output flow control stage: a one-entry output register between an upstream
// first-word-fall-through buffer and a downstream channel with full-style
// backpressure. It also tracks packet framing, flags framing errors and counts
// stall cycles.
//
// Handshake: a flit is transferred downstream in every cycle where val=1 and
// ret=0 (ret is "downstream full"). Upstream, buf_read=1 pops the head flit
// in the same cycle; buf_data is valid whenever buf_empty=0.
//
// dbg_state exposes the FSM encoding: 0 = IDLE, 1 = SEND, 2 = HOLD.
module output_flow_control #(
    parameter int FLIT_WIDTH = 34,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  buf_empty,
    input  logic [FLIT_WIDTH-1:0] buf_data,
    output logic                  buf_read,
    input  logic                  ret,
    output logic                  val,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic                  pkt_active,
    output logic                  proto_err,
    input  logic                  stall_clr,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_val;
    logic [FLIT_WIDTH-1:0] r_data;
    logic                  r_pkt_active;
    logic                  r_proto_err;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic                  w_acc;
    logic                  w_stall;
    logic                  w_buf_read;
    logic [1:0]            w_type;
    logic                  w_seq_err;

    // A flit leaves when it is valid and downstream is not full; the register
    // refills when it is empty or draining this cycle. Reset blocks any pop.
    assign w_acc      = r_val & ~ret;
    assign w_stall    = r_val & ret;
    assign w_buf_read = rst_n & ~buf_empty & (~r_val | ~ret);
    assign w_type     = r_data[FLIT_WIDTH-1 -: 2];

    // Framing check on the flit currently being accepted
    always_comb begin
        w_seq_err = 1'b0;
        if (w_acc) begin
            case (w_type)
                TYPE_HEAD, TYPE_SINGLE: w_seq_err = r_pkt_active;
                default:                w_seq_err = ~r_pkt_active;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_buf_read) w_state_nxt = SEND;
            end
            SEND, HOLD: begin
                if (ret)             w_state_nxt = HOLD;
                else if (w_buf_read) w_state_nxt = SEND;
                else                 w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output register: load on pop, drop on accept without refill, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= 1'b0;
            r_data <= '0;
        end else if (w_buf_read) begin
            r_val  <= 1'b1;
            r_data <= buf_data;
        end else if (w_acc) begin
            r_val  <= 1'b0;
        end
    end

    // Packet tracking: head opens a packet, tail closes it, single leaves it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_active <= 1'b0;
        end else if (w_acc) begin
            if (w_type == TYPE_HEAD)      r_pkt_active <= 1'b1;
            else if (w_type == TYPE_TAIL) r_pkt_active <= 1'b0;
        end
    end

    // Sticky framing error; clear wins over a simultaneous error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if (stall_clr) begin
            r_proto_err <= 1'b0;
        end else if (w_seq_err) begin
            r_proto_err <= 1'b1;
        end
    end

    // Saturating stall counter; clear wins over a simultaneous increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign buf_read   = w_buf_read;
    assign val        = r_val;
    assign data_out   = r_data;
    assign pkt_active = r_pkt_active;
    assign proto_err  = r_proto_err;
    assign stall_cnt  = r_stall_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_output_flow_control.sv
module tb_output_flow_control;

  localparam int FW = 34;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          buf_empty;
  logic [FW-1:0] buf_data;
  logic          ret;
  logic          stall_clr;

  logic          buf_read,  buf_read4;
  logic          val,       val4;
  logic [FW-1:0] data_out,  data_out4;
  logic          pkt_active, pkt_active4;
  logic          proto_err, proto_err4;
  logic [CW-1:0] stall_cnt;
  logic [3:0]    stall_cnt4;
  logic [1:0]    dbg_state, dbg_state4;

  output_flow_control #(.FLIT_WIDTH(FW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_read(buf_read), .ret(ret), .val(val), .data_out(data_out),
    .pkt_active(pkt_active), .proto_err(proto_err), .stall_clr(stall_clr),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // Narrow-counter instance sharing all inputs, for the saturation case
  output_flow_control #(.FLIT_WIDTH(FW), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_read(buf_read4), .ret(ret), .val(val4), .data_out(data_out4),
    .pkt_active(pkt_active4), .proto_err(proto_err4), .stall_clr(stall_clr),
    .stall_cnt(stall_cnt4), .dbg_state(dbg_state4)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [FW-1:0] buf_q[$];   // upstream buffer contents
  logic [FW-1:0] pend_q[$];  // flits to enter the buffer at the next drive point
  logic [FW-1:0] exp_q[$];   // flits expected downstream, in order

  bit            m_val, m_pkt, m_err, m_hold;
  logic [FW-1:0] m_data;
  int unsigned   m_cnt, m_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_pkt = 0; m_err = 0; m_hold = 0; m_data = '0;
    m_cnt = 0; m_cnt4 = 0;
    buf_q.delete(); pend_q.delete(); exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle
  task automatic model_tick();
    bit rd, acc, bad;
    logic [1:0] t;
    if (!rst_n) return;
    rd  = (buf_q.size() > 0) && (!m_val || !ret);
    acc = m_val && !ret;
    bad = 0;
    if (acc) begin
      t = m_data[FW-1:FW-2];
      if (t == 2'b01 || t == 2'b11) bad = m_pkt;
      else                          bad = !m_pkt;
      if (t == 2'b01) m_pkt = 1;
      if (t == 2'b10) m_pkt = 0;
    end
    if (stall_clr) begin
      m_err = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (bad) m_err = 1;
      if (m_val && ret) begin
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt4 < 15)    m_cnt4++;
      end
    end
    m_hold = m_val && ret;
    if (rd) begin
      m_data = buf_q.pop_front();
      m_val  = 1;
    end else if (acc) begin
      m_val = 0;
    end
  endtask

  task automatic check_all();
    logic exp_rd;
    logic [1:0] exp_st;
    logic [FW-1:0] sb;
    exp_rd = rst_n && (buf_q.size() > 0) && (!m_val || !ret);
    exp_st = !m_val ? 2'd0 : (m_hold ? 2'd2 : 2'd1);
    check("buf_read",    buf_read,    exp_rd);
    check("buf_read4",   buf_read4,   exp_rd);
    check("val",         val,         m_val);
    check("val4",        val4,        m_val);
    check("state",       dbg_state,   exp_st);
    check("state4",      dbg_state4,  exp_st);
    check("pkt_active",  pkt_active,  m_pkt);
    check("proto_err",   proto_err,   m_err);
    check("stall_cnt",   stall_cnt,   64'(m_cnt));
    check("stall_cnt4",  stall_cnt4,  64'(m_cnt4));
    if (m_val) check("data_out", data_out, m_data);
    if (rst_n && m_val && !ret) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_flit", 1'b1, 1'b0);
      end else begin
        sb = exp_q.pop_front();
        check("sb_order", data_out, sb);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_buf();
    buf_empty = (buf_q.size() == 0);
    buf_data  = (buf_q.size() > 0) ? buf_q[0] : '0;
  endtask

  task automatic add_flit(input logic [1:0] typ);
    logic [FW-1:0] f;
    f = {typ, 32'($urandom)};
    pend_q.push_back(f);
    exp_q.push_back(f);
  endtask

  task automatic gen_pkt(input bit corrupt);
    int len;
    logic [1:0] typ;
    len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++) begin
      if (len == 1)          typ = 2'b11;
      else if (i == 0)       typ = 2'b01;
      else if (i == len - 1) typ = 2'b10;
      else                   typ = 2'b00;
      if (corrupt) typ = 2'($urandom_range(0, 3));
      add_flit(typ);
    end
  endtask

  // One clock: model follows the edge, then new inputs, then check at negedge
  task automatic step(input logic r, input logic c);
    @(posedge clk);
    model_tick();
    #1;
    ret = r;
    stall_clr = c;
    while (pend_q.size() > 0) buf_q.push_back(pend_q.pop_front());
    drive_buf();
    @(negedge clk);
    check_all();
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; ret = 1'b0; stall_clr = 1'b0;
    buf_empty = 1'b1; buf_data = '0;
    model_reset();
    #12;
    check("reset_data_out", data_out, '0);
    check_all();
    rst_n = 1'b1;

    // Empty buffer with ret toggling: nothing moves
    for (int i = 0; i < 8; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // Streaming 4-flit packet with no backpressure
    add_flit(2'b01); add_flit(2'b00); add_flit(2'b00); add_flit(2'b10);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    check("stream_proto_err", proto_err, 1'b0);

    // Backpressure: three stalled cycles, then drain
    add_flit(2'b11); add_flit(2'b11);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("bp_stall_cnt", stall_cnt, 16'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Protocol error: body flit outside a packet, then clear
    add_flit(2'b00);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("perr_set", proto_err, 1'b1);
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    check("perr_clr", proto_err, 1'b0);

    // Saturation: ret held high for 20 stall cycles
    add_flit(2'b11);
    step(1'b0, 1'b1);
    for (int i = 0; i < 21; i++) step(1'b1, 1'b0);
    check("sat_cnt16", stall_cnt, 16'd20);
    check("sat_cnt4",  stall_cnt4, 4'd15);
    step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Reset while holding a stalled flit
    add_flit(2'b11); add_flit(2'b11);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    check("pre_rst_val", val, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_val_now",   val,       1'b0);
    check("rst_cnt_now",   stall_cnt, 16'd0);
    check("rst_data_now",  data_out,  '0);
    model_reset();
    buf_empty = 1'b0; buf_data = {2'b11, 32'hdeadbeef};
    #1;
    check("rst_no_pop", buf_read, 1'b0);
    buf_empty = 1'b1; buf_data = '0;
    step(1'b0, 1'b0); step(1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (pend_q.size() == 0 && buf_q.size() < 3 && $urandom_range(0, 2) == 0)
        gen_pkt($urandom_range(0, 9) == 0);
      step((i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0),
           $urandom_range(0, 29) == 0);
    end

    // Drain
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    check("drain_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", val, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
